// File: rtl/egress_crossbar.sv
// Four-input, four-output AXI-Stream packet switch. Each output owns a
// round-robin arbiter that stays locked to one input until that packet's tlast.
module egress_crossbar #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_0_tdata,
  input  logic                  in_0_tvalid,
  output logic                  in_0_tready,
  input  logic                  in_0_tlast,
  input  logic [1:0]            in_0_tdest,
  input  logic [DATA_WIDTH-1:0] in_1_tdata,
  input  logic                  in_1_tvalid,
  output logic                  in_1_tready,
  input  logic                  in_1_tlast,
  input  logic [1:0]            in_1_tdest,
  input  logic [DATA_WIDTH-1:0] in_2_tdata,
  input  logic                  in_2_tvalid,
  output logic                  in_2_tready,
  input  logic                  in_2_tlast,
  input  logic [1:0]            in_2_tdest,
  input  logic [DATA_WIDTH-1:0] in_3_tdata,
  input  logic                  in_3_tvalid,
  output logic                  in_3_tready,
  input  logic                  in_3_tlast,
  input  logic [1:0]            in_3_tdest,
  output logic [DATA_WIDTH-1:0] out_0_tdata,
  output logic                  out_0_tvalid,
  input  logic                  out_0_tready,
  output logic                  out_0_tlast,
  output logic [1:0]            out_0_tsrc,
  output logic [DATA_WIDTH-1:0] out_1_tdata,
  output logic                  out_1_tvalid,
  input  logic                  out_1_tready,
  output logic                  out_1_tlast,
  output logic [1:0]            out_1_tsrc,
  output logic [DATA_WIDTH-1:0] out_2_tdata,
  output logic                  out_2_tvalid,
  input  logic                  out_2_tready,
  output logic                  out_2_tlast,
  output logic [1:0]            out_2_tsrc,
  output logic [DATA_WIDTH-1:0] out_3_tdata,
  output logic                  out_3_tvalid,
  input  logic                  out_3_tready,
  output logic                  out_3_tlast,
  output logic [1:0]            out_3_tsrc
);

  localparam logic IDLE   = 1'b0;
  localparam logic LOCKED = 1'b1;

  logic [DATA_WIDTH-1:0] in_data [4];
  logic [1:0]            in_dest [4];
  logic [3:0]            in_valid, in_last, in_ready, in_busy;

  logic [DATA_WIDTH-1:0] out_data [4];
  logic [1:0]            out_src  [4];
  logic [3:0]            out_valid, out_last, out_ready;

  logic                  state      [4];
  logic [1:0]            grant      [4];
  logic [1:0]            last_grant [4];
  logic [3:0]            req        [4];
  logic [1:0]            pick       [4];
  logic [3:0]            pick_valid, space, accept;

  logic [1:0]            rst_sync;
  logic                  rst;

  assign in_data  = '{in_0_tdata, in_1_tdata, in_2_tdata, in_3_tdata};
  assign in_dest  = '{in_0_tdest, in_1_tdest, in_2_tdest, in_3_tdest};
  assign in_valid = {in_3_tvalid, in_2_tvalid, in_1_tvalid, in_0_tvalid};
  assign in_last  = {in_3_tlast, in_2_tlast, in_1_tlast, in_0_tlast};
  assign out_ready = {out_3_tready, out_2_tready, out_1_tready, out_0_tready};

  assign {in_3_tready, in_2_tready, in_1_tready, in_0_tready} = in_ready;
  assign {out_3_tvalid, out_2_tvalid, out_1_tvalid, out_0_tvalid} = out_valid;
  assign {out_3_tlast, out_2_tlast, out_1_tlast, out_0_tlast} = out_last;
  assign out_0_tdata = out_data[0];
  assign out_1_tdata = out_data[1];
  assign out_2_tdata = out_data[2];
  assign out_3_tdata = out_data[3];
  assign out_0_tsrc  = out_src[0];
  assign out_1_tsrc  = out_src[1];
  assign out_2_tsrc  = out_src[2];
  assign out_3_tsrc  = out_src[3];

  // Reset asserts immediately but releases two clock edges later, on clk.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst = rst_sync[1];

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    in_busy  = '0;
    in_ready = '0;
    for (int m = 0; m < 4; m++) begin
      space[m] = !out_valid[m] || out_ready[m];
      if (state[m] == LOCKED) begin
        in_busy[grant[m]] = 1'b1;
        if (space[m]) in_ready[grant[m]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 4; i++)
        req[m][i] = in_valid[i] && (in_dest[i] == 2'(m)) && !in_busy[i];
      pick_valid[m] = 1'b0;
      pick[m]       = last_grant[m];
      // Scan downward so the nearest requester after last_grant wins.
      for (int k = 4; k >= 1; k--) begin
        if (req[m][last_grant[m] + 2'(k)]) begin
          pick_valid[m] = 1'b1;
          pick[m]       = last_grant[m] + 2'(k);
        end
      end
      accept[m] = (state[m] == LOCKED) && in_valid[grant[m]] && space[m];
    end
  end

  // NOTE: output registers are reset explicitly since their reset values are visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_last  <= '0;
      for (int m = 0; m < 4; m++) begin
        state[m]      <= IDLE;
        grant[m]      <= 2'd0;
        last_grant[m] <= 2'd3;
        out_data[m]   <= '0;
        out_src[m]    <= 2'd0;
      end
    end else begin
      for (int m = 0; m < 4; m++) begin
        if (state[m] == IDLE) begin
          if (pick_valid[m]) begin
            state[m]      <= LOCKED;
            grant[m]      <= pick[m];
            last_grant[m] <= pick[m];
          end
        end else if (accept[m] && in_last[grant[m]]) begin
          state[m] <= IDLE;
        end

        if (accept[m]) begin
          out_valid[m] <= 1'b1;
          out_data[m]  <= in_data[grant[m]];
          out_last[m]  <= in_last[grant[m]];
          out_src[m]   <= grant[m];
        end else if (out_ready[m]) begin
          out_valid[m] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_egress_crossbar.sv
// Directed bench for egress_crossbar: a per-cycle vector table for single-packet
// and backpressure traffic, then queue-driven sequences for multi-packet cases.
module tb_egress_crossbar;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_tdata  [4];
  logic [3:0]  in_tvalid, in_tready, in_tlast;
  logic [1:0]  in_tdest  [4];
  logic [15:0] out_tdata [4];
  logic [3:0]  out_tvalid, out_tready, out_tlast;
  logic [1:0]  out_tsrc  [4];

  always #5 clk = ~clk;

  egress_crossbar #(.DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .in_0_tdata(in_tdata[0]), .in_0_tvalid(in_tvalid[0]), .in_0_tready(in_tready[0]),
    .in_0_tlast(in_tlast[0]), .in_0_tdest(in_tdest[0]),
    .in_1_tdata(in_tdata[1]), .in_1_tvalid(in_tvalid[1]), .in_1_tready(in_tready[1]),
    .in_1_tlast(in_tlast[1]), .in_1_tdest(in_tdest[1]),
    .in_2_tdata(in_tdata[2]), .in_2_tvalid(in_tvalid[2]), .in_2_tready(in_tready[2]),
    .in_2_tlast(in_tlast[2]), .in_2_tdest(in_tdest[2]),
    .in_3_tdata(in_tdata[3]), .in_3_tvalid(in_tvalid[3]), .in_3_tready(in_tready[3]),
    .in_3_tlast(in_tlast[3]), .in_3_tdest(in_tdest[3]),
    .out_0_tdata(out_tdata[0]), .out_0_tvalid(out_tvalid[0]), .out_0_tready(out_tready[0]),
    .out_0_tlast(out_tlast[0]), .out_0_tsrc(out_tsrc[0]),
    .out_1_tdata(out_tdata[1]), .out_1_tvalid(out_tvalid[1]), .out_1_tready(out_tready[1]),
    .out_1_tlast(out_tlast[1]), .out_1_tsrc(out_tsrc[1]),
    .out_2_tdata(out_tdata[2]), .out_2_tvalid(out_tvalid[2]), .out_2_tready(out_tready[2]),
    .out_2_tlast(out_tlast[2]), .out_2_tsrc(out_tsrc[2]),
    .out_3_tdata(out_tdata[3]), .out_3_tvalid(out_tvalid[3]), .out_3_tready(out_tready[3]),
    .out_3_tlast(out_tlast[3]), .out_3_tsrc(out_tsrc[3])
  );

  typedef struct {
    int          src;
    int          dst;
    logic        valid;
    logic [15:0] data;
    logic        last;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_ov;
    logic [15:0] exp_od;
    logic        exp_ol;
    logic [1:0]  exp_os;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [1:0]  dest;
  } beat_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [1:0]  src;
    int          cyc;
  } obs_t;

  vec_t       vecs [$];
  beat_t      src_q [4][$];
  obs_t       obs_q [4][$];
  logic [3:0] oready_drive;
  int         cyc;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int src, int dst, logic v, logic [15:0] d, logic l, logic r,
                              logic er, logic eov, logic [15:0] eod, logic eol, logic [1:0] eos);
    vec_t x;
    x.src = src; x.dst = dst; x.valid = v; x.data = d; x.last = l; x.ordy = r;
    x.exp_rdy = er; x.exp_ov = eov; x.exp_od = eod; x.exp_ol = eol; x.exp_os = eos;
    return x;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      in_tdata[i] = '0;
      in_tdest[i] = '0;
    end
    in_tvalid = '0;
    in_tlast  = '0;
  endtask

  // Leaves the bench 1 time unit after a rising edge, with the internal reset released.
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    out_tready   = 4'hF;
    oready_drive = 4'hF;
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      obs_q[i].delete();
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 cyc = 0;
  endtask

  task automatic add_pkt(input int i, input logic [1:0] dest, input logic [15:0] base, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + 16'(k);
      b.last = (k == n - 1);
      b.dest = dest;
      src_q[i].push_back(b);
    end
  endtask

  // One clock: drive queue heads, record handshakes at the falling edge.
  task automatic step();
    obs_t o;
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        in_tvalid[i] = 1'b1;
        in_tdata[i]  = src_q[i][0].data;
        in_tlast[i]  = src_q[i][0].last;
        in_tdest[i]  = src_q[i][0].dest;
      end
    end
    out_tready = oready_drive;
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      if (out_tvalid[m] && out_tready[m]) begin
        o.data = out_tdata[m]; o.last = out_tlast[m]; o.src = out_tsrc[m]; o.cyc = cyc;
        obs_q[m].push_back(o);
      end
    end
    for (int i = 0; i < 4; i++)
      if (in_tvalid[i] && in_tready[i]) void'(src_q[i].pop_front());
    @(posedge clk);
    #1 cyc++;
  endtask

  function automatic logic busy();
    for (int i = 0; i < 4; i++)
      if (src_q[i].size() > 0) return 1'b1;
    return |out_tvalid;
  endfunction

  task automatic run_drain(input string name, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check({name, " drained in budget"}, 32'(n < budget), 32'd1);
    clear_inputs();
  endtask

  task automatic check_stream(input string name, input int m, input int start, input int n,
                              input logic [1:0] src, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      if (start + k >= obs_q[m].size()) begin
        check({name, " beat count"}, 32'(obs_q[m].size()), 32'(start + n));
        return;
      end
      check($sformatf("%s beat%0d data", name, k), obs_q[m][start+k].data, base + 16'(k));
      check($sformatf("%s beat%0d tsrc", name, k), obs_q[m][start+k].src, src);
      check($sformatf("%s beat%0d tlast", name, k), obs_q[m][start+k].last, 32'(k == n - 1));
      if (k > 0)
        check($sformatf("%s beat%0d spacing", name, k),
              32'(obs_q[m][start+k].cyc - obs_q[m][start+k-1].cyc), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic [3:0] mask;

    // Single packet in0 -> out2, then in2 -> out0 with a 5-cycle stall.
    vecs.push_back(mk(0, 2, 1, 16'hA001, 0, 1, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 2, 1, 16'hA001, 0, 1, 1, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 2, 1, 16'hA002, 0, 1, 1, 1, 16'hA001, 0, 0));
    vecs.push_back(mk(0, 2, 1, 16'hA003, 1, 1, 1, 1, 16'hA002, 0, 0));
    vecs.push_back(mk(0, 2, 0, 16'h0000, 0, 1, 0, 1, 16'hA003, 1, 0));
    vecs.push_back(mk(0, 2, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(2, 0, 1, 16'h0010, 0, 1, 0, 0, 16'h0000, 0, 2));
    vecs.push_back(mk(2, 0, 1, 16'h0010, 0, 1, 1, 0, 16'h0000, 0, 2));
    vecs.push_back(mk(2, 0, 1, 16'h0011, 0, 1, 1, 1, 16'h0010, 0, 2));
    for (int s = 0; s < 5; s++)
      vecs.push_back(mk(2, 0, 1, 16'h0012, 0, 0, 0, 1, 16'h0011, 0, 2));
    vecs.push_back(mk(2, 0, 1, 16'h0012, 0, 1, 1, 1, 16'h0011, 0, 2));
    vecs.push_back(mk(2, 0, 1, 16'h0013, 0, 1, 1, 1, 16'h0012, 0, 2));
    vecs.push_back(mk(2, 0, 1, 16'h0014, 0, 1, 1, 1, 16'h0013, 0, 2));
    vecs.push_back(mk(2, 0, 1, 16'h0015, 1, 1, 1, 1, 16'h0014, 0, 2));
    vecs.push_back(mk(2, 0, 0, 16'h0000, 0, 1, 0, 1, 16'h0015, 1, 2));
    vecs.push_back(mk(2, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 2));

    // Reset values while reset is held.
    clear_inputs();
    out_tready = 4'hF;
    @(negedge clk);
    @(negedge clk);
    check("reset in tready", in_tready, 4'h0);
    check("reset out tvalid", out_tvalid, 4'h0);
    check("reset out tlast", out_tlast, 4'h0);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("reset out%0d tdata", m), out_tdata[m], 16'h0);
      check($sformatf("reset out%0d tsrc", m), out_tsrc[m], 2'd0);
    end

    do_reset();
    for (int n = 0; n < vecs.size(); n++) begin
      v = vecs[n];
      clear_inputs();
      in_tvalid[v.src] = v.valid;
      in_tdata[v.src]  = v.data;
      in_tlast[v.src]  = v.last;
      in_tdest[v.src]  = 2'(v.dst);
      out_tready       = 4'hF;
      out_tready[v.dst] = v.ordy;
      @(negedge clk);
      check($sformatf("vec%0d in%0d tready", n, v.src), in_tready[v.src], v.exp_rdy);
      mask = in_tready;
      mask[v.src] = 1'b0;
      check($sformatf("vec%0d other treadys", n), mask, 4'h0);
      check($sformatf("vec%0d out%0d tvalid", n, v.dst), out_tvalid[v.dst], v.exp_ov);
      if (v.exp_ov) begin
        check($sformatf("vec%0d out%0d tdata", n, v.dst), out_tdata[v.dst], v.exp_od);
        check($sformatf("vec%0d out%0d tlast", n, v.dst), out_tlast[v.dst], v.exp_ol);
        check($sformatf("vec%0d out%0d tsrc", n, v.dst), out_tsrc[v.dst], v.exp_os);
      end
      mask = out_tvalid;
      mask[v.dst] = 1'b0;
      check($sformatf("vec%0d other tvalids", n), mask, 4'h0);
      @(posedge clk);
      #1;
    end

    // Contention: in0 and in1 both target out1 in the same cycle.
    do_reset();
    add_pkt(0, 2'd1, 16'h0100, 4);
    add_pkt(1, 2'd1, 16'h0200, 4);
    run_drain("contention", 100);
    check("contention beats", 32'(obs_q[1].size()), 32'd8);
    check("contention others", 32'(obs_q[0].size() + obs_q[2].size() + obs_q[3].size()), 32'd0);
    check_stream("contention in0", 1, 0, 4, 2'd0, 16'h0100);
    check_stream("contention in1", 1, 4, 4, 2'd1, 16'h0200);
    if (obs_q[1].size() >= 5) begin
      check("contention first cycle", 32'(obs_q[1][0].cyc), 32'd2);
      check("contention gap", 32'(obs_q[1][4].cyc - obs_q[1][3].cyc), 32'd2);
    end

    // Round robin: four inputs, three 1-beat packets each, all to out3.
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++)
        add_pkt(i, 2'd3, 16'h3000 + 16'(i * 16 + p), 1);
    run_drain("round robin", 200);
    check("rr beats", 32'(obs_q[3].size()), 32'd12);
    for (int k = 0; k < 12 && k < obs_q[3].size(); k++) begin
      check($sformatf("rr beat%0d tsrc", k), obs_q[3][k].src, 32'(k % 4));
      check($sformatf("rr beat%0d data", k), obs_q[3][k].data, 32'(16'h3000 + (k % 4) * 16 + k / 4));
      check($sformatf("rr beat%0d tlast", k), obs_q[3][k].last, 32'd1);
      if (k > 0)
        check($sformatf("rr beat%0d spacing", k), 32'(obs_q[3][k].cyc - obs_q[3][k-1].cyc), 32'd2);
    end

    // Parallel: four disjoint 8-beat flows.
    do_reset();
    add_pkt(0, 2'd1, 16'h1000, 8);
    add_pkt(1, 2'd0, 16'h1100, 8);
    add_pkt(2, 2'd3, 16'h1200, 8);
    add_pkt(3, 2'd2, 16'h1300, 8);
    run_drain("parallel", 100);
    check_stream("par out1", 1, 0, 8, 2'd0, 16'h1000);
    check_stream("par out0", 0, 0, 8, 2'd1, 16'h1100);
    check_stream("par out3", 3, 0, 8, 2'd2, 16'h1200);
    check_stream("par out2", 2, 0, 8, 2'd3, 16'h1300);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("par out%0d beats", m), 32'(obs_q[m].size()), 32'd8);
      if (obs_q[m].size() > 0)
        check($sformatf("par out%0d first cycle", m), 32'(obs_q[m][0].cyc), 32'd2);
    end

    // Reset on the third beat of a 5-beat in1 -> out0 packet.
    do_reset();
    add_pkt(1, 2'd0, 16'h0300, 5);
    for (int n = 0; n < 20 && src_q[1].size() > 3; n++) step();
    check("midreset two beats taken", 32'(src_q[1].size()), 32'd3);
    in_tvalid[1] = 1'b1;
    in_tdata[1]  = 16'h0302;
    in_tdest[1]  = 2'd0;
    #2;
    check("midreset out0 busy before", out_tvalid[0], 1'b1);
    reset = 1'b1;
    #1;
    check("midreset out0 tvalid", out_tvalid[0], 1'b0);
    check("midreset out0 tdata", out_tdata[0], 16'h0);
    check("midreset in1 tready", in_tready[1], 1'b0);
    do_reset();
    add_pkt(0, 2'd0, 16'h0400, 2);
    add_pkt(1, 2'd0, 16'h0300, 5);
    run_drain("post reset", 100);
    check("post reset beats", 32'(obs_q[0].size()), 32'd7);
    check_stream("post reset in0", 0, 0, 2, 2'd0, 16'h0400);
    check_stream("post reset in1", 0, 2, 5, 2'd1, 16'h0300);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/egress_crossbar.md
# egress_crossbar

- Four-input, four-output AXI-Stream packet switch.
- Sits downstream of the ingress filters and consumes their `tdest`-tagged egress streams.
- Each packet is steered to the output port named by its `tdest`. Each output has its own round-robin arbiter that stays locked to one input until that packet's `tlast`, so packets never interleave.
- A single registered output stage per port gives 1-cycle data latency at full beat throughput.

## Interface
Parameters:
- `DATA_WIDTH`, 16, `tdata` width of every port.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_N_tdata`  in  DATA_WIDTH  ingress data, N = 0..3.
- `in_N_tvalid`  in  1  ingress beat valid.
- `in_N_tready`  out  1  ingress beat accepted.
- `in_N_tlast`  in  1  last beat of packet.
- `in_N_tdest`  in  2  destination output index; held constant by the source for a whole packet.
- `out_M_tdata`  out  DATA_WIDTH  egress data, M = 0..3.
- `out_M_tvalid`  out  1  egress beat valid.
- `out_M_tready`  in  1  egress consumer ready.
- `out_M_tlast`  out  1  last beat of packet.
- `out_M_tsrc`  out  2  index of the input that supplied the beat.

## Operation
- Request: input i requests output M when `in_i_tvalid && in_i_tdest == M` and input i is not already granted.
- Per-output FSM has two states.
  - IDLE: no grant. If any request is present, grant the first requester scanning from `(last_grant+1) mod 4` upward. Register `grant`, set `last_grant`, go to LOCKED.
  - LOCKED(i): input i is routed to output M. Return to IDLE in the cycle after the beat with `tlast` is accepted from input i.
- While LOCKED, `in_i_tdest` is ignored. Routing comes only from `grant`.
- An input is granted by at most one output at a time.
- `in_i_tready = LOCKED(i) at some M && (!out_M_tvalid || out_M_tready)`. Every other input sees `tready` = 0.
- Output register: on accept (`in_i_tvalid && in_i_tready`), load `tdata`, `tlast`, and `tsrc = i`, and set `out_M_tvalid` = 1.
  - If there is no accept and `out_M_tready` is high, clear `out_M_tvalid`.
  - While `out_M_tvalid && !out_M_tready`, all `out_M_*` hold stable.
- Single-beat packets (`tlast` on the first beat) grant, transfer and release normally.
- Inputs not requesting any output see `tready` = 0. No beat is dropped or duplicated.

## Timing
- Reset (async assert, release synchronised to `clk` by the design):
  - all `in_N_tready` = 0
  - `out_M_tvalid` = 0, `out_M_tlast` = 0, `out_M_tdata` = 0, `out_M_tsrc` = 0
  - FSMs in IDLE; `last_grant` = 3, so input 0 has first priority.
- Reset mid-packet: partial packets are discarded and output registers cleared. The source must restart the packet.
- Arbitration:
  - Request visible in cycle t → grant registered at edge t+1 → first beat accepted in cycle t+1 if output space exists.
  - The 1-cycle arbitration bubble applies to every packet.
- Data: beat accepted in cycle t → `out_M_tvalid` high from edge t+1.
- Sustained throughput while LOCKED with `out_M_tready` = 1: one beat per cycle.
- Packet occupancy: N beats take N + 1 cycles of output bandwidth.
- `tlast` release: beat with `tlast` accepted in cycle t → IDLE at edge t+1 → next grant at edge t+2. Outputs stay independent: all four can stream concurrently.
- Simultaneous requests from several inputs to one output: exactly one grant, the lowest index at or after `last_grant+1` (wrap 3→0).
- A request arriving the same cycle another output releases: handled only by the FSM of the requested output. No cross-output coupling.

## Test plan
- Single packet:
  - Stimulus: after reset, in0 sends `tdest`=2 with beats 0xA001, 0xA002, 0xA003 (`tlast` on the third).
  - Required: out2 shows the same three beats in order, `tsrc`=0, `tlast` only on 0xA003, first beat 2 cycles after `tvalid` rises.
  - Required: out0, out1 and out3 keep `tvalid` = 0.
- Contention:
  - Stimulus: in0 and in1 both present 4-beat packets to `tdest`=1 in the same cycle after reset.
  - Required: out1 carries all of in0's packet (`tsrc`=0), one idle cycle, then all of in1's packet (`tsrc`=1). No interleaving.
- Round robin:
  - Stimulus: all four inputs continuously offer 1-beat packets to out3, with `out3_tready`=1.
  - Required: `tsrc` sequence 0,1,2,3,0,1,… with one beat every 2 cycles.
- Backpressure:
  - Stimulus: in2 sends 6 beats 0x0010..0x0015 to out0; `out0_tready` is held low for 5 cycles after the second beat.
  - Required: `out0_tdata` holds stable at 0x0011 and `in2_tready` = 0 for the stall; all 6 beats are delivered exactly once.
- Parallel:
  - Stimulus: concurrent 8-beat packets in0→1, in1→0, in2→3, in3→2 with all `tready`=1.
  - Required: all four outputs stream one beat per cycle simultaneously, each with the correct `tsrc`.
- Reset mid-packet:
  - Stimulus: assert `reset` on the third beat of a 5-beat in1→0 packet.
  - Required: `out0_tvalid` = 0 immediately (asynchronous). After release, in0 and in1 both request out0 and in0 wins first.
